// File: rtl/pipe_pkg.sv
// Shared types and constants for the IF/ID pipeline register slice.
package pipe_pkg;

    localparam int unsigned XLEN_DEF = 32;
    localparam int unsigned ILEN_DEF = 32;

    // addi x0,x0,0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [ILEN_DEF-1:0] instr;
        logic [XLEN_DEF-1:0] pc;
        logic [XLEN_DEF-1:0] pcplus4;
    } if_id_t;

endpackage

// File: rtl/pipe_skid_reg.sv
// Generic valid/ready register with optional second (skid) entry and flush.
module pipe_skid_reg #(
    parameter int unsigned W    = 96,
    parameter bit          SKID = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         flush,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready
);

    logic         main_v, main_v_nxt;
    logic         skid_v, skid_v_nxt;
    logic [W-1:0] main_d, main_d_nxt;
    logic [W-1:0] skid_d, skid_d_nxt;
    logic         push, pop;

    // With a skid entry, ready depends only on the skid flop.
    assign in_ready  = SKID ? !skid_v : (!main_v || out_ready);
    assign push      = in_valid && in_ready;
    assign pop       = main_v && out_ready;
    assign out_data  = main_d;
    assign out_valid = main_v;

    always_comb begin
        main_v_nxt = main_v;
        main_d_nxt = main_d;
        skid_v_nxt = skid_v;
        skid_d_nxt = skid_d;
        if (flush) begin
            main_v_nxt = 1'b0;
            skid_v_nxt = 1'b0;
        end else if (pop && skid_v) begin
            main_d_nxt = skid_d;
            skid_v_nxt = 1'b0;
        end else if (push && (!main_v || pop)) begin
            main_v_nxt = 1'b1;
            main_d_nxt = in_data;
        end else if (push) begin
            skid_v_nxt = 1'b1;
            skid_d_nxt = in_data;
        end else if (pop) begin
            main_v_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_v <= 1'b0;
            skid_v <= 1'b0;
            main_d <= '0;
            skid_d <= '0;
        end else begin
            main_v <= main_v_nxt;
            skid_v <= skid_v_nxt;
            main_d <= main_d_nxt;
            skid_d <= skid_d_nxt;
        end
    end

endmodule

// File: rtl/if_id_pipe.sv
// IF/ID pipeline stage: carries instruction, PC and PC+4 from fetch to decode.
module if_id_pipe
    import pipe_pkg::*;
#(
    parameter int unsigned      XLEN = 32,
    parameter int unsigned      ILEN = 32,
    parameter logic [ILEN-1:0]  NOP  = ILEN'(NOP_INSTR),
    parameter bit               SKID = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [ILEN-1:0] InstrF,
    input  logic [XLEN-1:0] PCF,
    input  logic [XLEN-1:0] PCPlus4F,
    input  logic            ValidF,
    output logic            ReadyF,
    input  logic            StallD,
    input  logic            FlushD,
    output logic [ILEN-1:0] InstrD,
    output logic [XLEN-1:0] PCD,
    output logic [XLEN-1:0] PCPlus4D,
    output logic            ValidD
);

    localparam int unsigned PW = ILEN + 2 * XLEN;

    logic [PW-1:0]   in_data;
    logic [PW-1:0]   out_data;
    logic [ILEN-1:0] instr_q;

    assign in_data = {InstrF, PCF, PCPlus4F};

    pipe_skid_reg #(
        .W    (PW),
        .SKID (SKID)
    ) u_reg (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (ValidF),
        .in_ready  (ReadyF),
        .flush     (FlushD),
        .out_data  (out_data),
        .out_valid (ValidD),
        .out_ready (!StallD)
    );

    assign {instr_q, PCD, PCPlus4D} = out_data;

    // Decode sees a bubble whenever the main entry is empty.
    assign InstrD = ValidD ? instr_q : NOP;

endmodule

// File: tb/tb_if_id_pipe.sv
// Bench for if_id_pipe: SKID=1 and SKID=0 instances checked against a queue model.
module tb_if_id_pipe;
    import pipe_pkg::*;

    localparam logic [31:0] NOPV = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr_f   [2];
    logic [31:0] pc_f      [2];
    logic [31:0] pcplus4_f [2];
    logic        valid_f   [2];
    logic        stall_d   [2];
    logic        flush_d   [2];
    logic        ready_f   [2];
    logic [31:0] instr_d   [2];
    logic [31:0] pc_d      [2];
    logic [31:0] pcplus4_d [2];
    logic        valid_d   [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk_instr(input logic [31:0] pc);
        return {pc[29:0], 2'b11} ^ 32'h5A00_0000;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_inst
        if_id_pipe #(.XLEN(32), .ILEN(32), .SKID(g == 1)) dut (
            .clk      (clk),
            .reset    (reset),
            .InstrF   (instr_f[g]),
            .PCF      (pc_f[g]),
            .PCPlus4F (pcplus4_f[g]),
            .ValidF   (valid_f[g]),
            .ReadyF   (ready_f[g]),
            .StallD   (stall_d[g]),
            .FlushD   (flush_d[g]),
            .InstrD   (instr_d[g]),
            .PCD      (pc_d[g]),
            .PCPlus4D (pcplus4_d[g]),
            .ValidD   (valid_d[g])
        );

        // Model: the stage is a FIFO of capacity 2 (skid) or 1 (no skid).
        if_id_t q[$];
        if_id_t last;

        function automatic logic exp_ready();
            if (g == 1) return q.size() < 2;
            return (q.size() == 0) || !stall_d[g];
        endfunction

        always @(posedge clk or posedge reset) begin
            if (reset) begin
                q.delete();
                last = '0;
            end else begin
                logic   push;
                if_id_t e;
                push = valid_f[g] && exp_ready();
                e = '{instr: instr_f[g], pc: pc_f[g], pcplus4: pcplus4_f[g]};
                if (flush_d[g]) begin
                    q.delete();
                end else begin
                    if (q.size() > 0 && !stall_d[g]) void'(q.pop_front());
                    if (push) q.push_back(e);
                end
                if (q.size() > 0) last = q[0];
            end
        end

        always @(negedge clk) begin
            logic ev;
            ev = q.size() > 0;
            chk($sformatf("s%0d_valid", g), 32'(valid_d[g]), 32'(ev));
            chk($sformatf("s%0d_instr", g), instr_d[g], ev ? q[0].instr : NOPV);
            chk($sformatf("s%0d_pc", g), pc_d[g], last.pc);
            chk($sformatf("s%0d_pcplus4", g), pcplus4_d[g], last.pcplus4);
            chk($sformatf("s%0d_ready", g), 32'(ready_f[g]), 32'(exp_ready()));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int g, input logic v, input logic [31:0] pc,
                         input logic st, input logic fl);
        valid_f[g]   = v;
        pc_f[g]      = pc;
        pcplus4_f[g] = pc + 32'd4;
        instr_f[g]   = mk_instr(pc);
        stall_d[g]   = st;
        flush_d[g]   = fl;
    endtask

    task automatic at_neg();
        @(negedge clk);
        #1;
    endtask

    logic [31:0] pcnt [2];

    initial begin
        reset = 1'b1;
        for (int g = 0; g < 2; g++) drive(g, 1'b0, 32'h0, 1'b0, 1'b0);
        at_neg();
        for (int g = 0; g < 2; g++) begin
            chk("rst_valid", 32'(valid_d[g]), 32'h0);
            chk("rst_instr", instr_d[g], 32'h13);
            chk("rst_pc", pc_d[g], 32'h0);
            chk("rst_ready", 32'(ready_f[g]), 32'h1);
        end
        step();
        reset = 1'b0;
        step();

        // Streaming, SKID=1
        drive(1, 1'b1, 32'h0, 1'b0, 1'b0); step();
        drive(1, 1'b1, 32'h4, 1'b0, 1'b0); at_neg();
        chk("stream_pc0", pc_d[1], 32'h0); chk("stream_v0", 32'(valid_d[1]), 32'h1);
        step();
        drive(1, 1'b1, 32'h8, 1'b0, 1'b0); at_neg();
        chk("stream_pc4", pc_d[1], 32'h4);
        step();
        drive(1, 1'b0, 32'h0, 1'b0, 1'b0); at_neg();
        chk("stream_pc8", pc_d[1], 32'h8); chk("stream_instr8", instr_d[1], mk_instr(32'h8));
        step(); at_neg();
        chk("drain_valid", 32'(valid_d[1]), 32'h0); chk("drain_instr", instr_d[1], 32'h13);
        chk("drain_pc_hold", pc_d[1], 32'h8);

        // Stall with skid, SKID=1
        step();
        drive(1, 1'b1, 32'h100, 1'b0, 1'b0); step();
        drive(1, 1'b1, 32'h104, 1'b1, 1'b0); at_neg();
        chk("stall_pcA", pc_d[1], 32'h100); chk("stall_rdy_pre", 32'(ready_f[1]), 32'h1);
        step();
        drive(1, 1'b0, 32'h0, 1'b1, 1'b0); at_neg();
        chk("stall_rdy_low1", 32'(ready_f[1]), 32'h0); chk("stall_hold1", pc_d[1], 32'h100);
        step(); at_neg();
        chk("stall_rdy_low2", 32'(ready_f[1]), 32'h0); chk("stall_hold2", pc_d[1], 32'h100);
        step();
        drive(1, 1'b0, 32'h0, 1'b0, 1'b0); at_neg();
        chk("stall_hold3", pc_d[1], 32'h100);
        step(); at_neg();
        chk("release_pcB", pc_d[1], 32'h104); chk("release_rdy", 32'(ready_f[1]), 32'h1);
        step(); step();

        // Flush with stall, push and full skid, SKID=1
        drive(1, 1'b1, 32'h180, 1'b0, 1'b0); step();
        drive(1, 1'b1, 32'h184, 1'b1, 1'b0); step();
        drive(1, 1'b1, 32'h200, 1'b1, 1'b1); at_neg();
        chk("flush_pre_rdy", 32'(ready_f[1]), 32'h0);
        step();
        drive(1, 1'b0, 32'h0, 1'b0, 1'b0); at_neg();
        chk("flush_valid", 32'(valid_d[1]), 32'h0); chk("flush_instr", instr_d[1], 32'h13);
        chk("flush_rdy", 32'(ready_f[1]), 32'h1); chk("flush_pc_hold", pc_d[1], 32'h180);
        step(); at_neg();
        chk("flush_no200", pc_d[1], 32'h180); chk("flush_valid2", 32'(valid_d[1]), 32'h0);

        // Back-pressure, SKID=0
        drive(0, 1'b1, 32'h300, 1'b0, 1'b0); step();
        drive(0, 1'b1, 32'h304, 1'b1, 1'b0); at_neg();
        chk("s0_pc300", pc_d[0], 32'h300); chk("s0_rdy_stall", 32'(ready_f[0]), 32'h0);
        step();
        drive(0, 1'b1, 32'h304, 1'b0, 1'b0); at_neg();
        chk("s0_rdy_release", 32'(ready_f[0]), 32'h1); chk("s0_hold300", pc_d[0], 32'h300);
        step();
        drive(0, 1'b0, 32'h0, 1'b0, 1'b0); at_neg();
        chk("s0_pc304", pc_d[0], 32'h304);
        step(); step();

        // Reset mid-stream with ValidD=1
        drive(1, 1'b1, 32'h400, 1'b1, 1'b0); step();
        drive(1, 1'b0, 32'h0, 1'b1, 1'b0);
        #2;
        chk("mid_pre_valid", 32'(valid_d[1]), 32'h1);
        reset = 1'b1;
        #1;
        chk("mid_valid", 32'(valid_d[1]), 32'h0); chk("mid_instr", instr_d[1], 32'h13);
        chk("mid_pc", pc_d[1], 32'h0); chk("mid_rdy", 32'(ready_f[1]), 32'h1);
        step();
        reset = 1'b0;
        drive(1, 1'b0, 32'h0, 1'b0, 1'b0);
        step();

        // Random traffic on both instances
        pcnt[0] = 32'h1000_0000;
        pcnt[1] = 32'h2000_0000;
        for (int c = 0; c < 5000; c++) begin
            for (int g = 0; g < 2; g++) begin
                drive(g, $urandom_range(99) < 70, pcnt[g],
                      $urandom_range(99) < 30, $urandom_range(99) < 5);
                pcnt[g] = pcnt[g] + 32'd4;
            end
            step();
        end
        for (int g = 0; g < 2; g++) drive(g, 1'b0, 32'h0, 1'b0, 1'b0);
        step(); step(); step();
        at_neg();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
